// File: rtl/neuron_step_scheduler.sv
// rtl/neuron_step_scheduler.sv - sequences one updateNeuron engine over neurons and timesteps
module neuron_step_scheduler #(
  parameter int N_NEURON = 18,
  parameter int STEP_W   = 16,
  parameter int TIMEOUT  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic                i_init_req,
  input  logic                i_learn,
  input  logic [STEP_W-1:0]   i_num_steps,
  output logic                o_cur_req,
  output logic [4:0]          o_cur_idx,
  input  logic                i_cur_valid,
  input  logic [24:0]         i_exc_cur,
  input  logic [24:0]         i_inh_cur,
  output logic                o_run,
  output logic                o_init,
  output logic                o_s_lern,
  output logic                o_s_infr,
  output logic [24:0]         o_exc_current,
  output logic [24:0]         o_inh_current,
  input  logic                i_spike,
  input  logic                i_valid,
  input  logic [4:0]          i_neuron_idx,
  output logic                o_busy,
  output logic [N_NEURON-1:0] o_spike_vec,
  output logic                o_step_valid,
  output logic [STEP_W-1:0]   o_step_cnt,
  output logic                o_done,
  output logic                o_err
);

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_INIT_WAIT, S_REQ, S_RUN, S_WAIT, S_STEP_END, S_DONE
  } state_t;

  state_t              state, state_nx;
  logic [4:0]          idx;
  logic                learn_r;
  logic [STEP_W-1:0]   steps_r;
  logic [STEP_W-1:0]   step_cnt;
  logic [CNT_W-1:0]    cnt;
  logic [24:0]         exc_r, inh_r;
  logic [N_NEURON-1:0] shadow;
  logic [N_NEURON-1:0] spike_vec;
  logic                err;
  logic                step_valid;

  logic last_idx, timeout_hit, step_last, neuron_done;
  assign last_idx    = (idx == 5'(N_NEURON - 1));
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
  assign step_last   = ((step_cnt + STEP_W'(1)) == steps_r);
  assign neuron_done = i_valid || timeout_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    o_init    = 1'b0;
    o_run     = 1'b0;
    o_cur_req = 1'b0;
    o_done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          if (i_init_req)              state_nx = S_INIT;
          else if (i_num_steps == '0)  state_nx = S_DONE;
          else                         state_nx = S_REQ;
        end
      end
      S_INIT: begin
        o_init   = 1'b1;
        state_nx = S_INIT_WAIT;
      end
      // engine sweeps every neuron once, then needs one idle cycle
      S_INIT_WAIT: begin
        if (cnt == CNT_W'(N_NEURON))
          state_nx = (steps_r == '0) ? S_DONE : S_REQ;
      end
      S_REQ: begin
        o_cur_req = 1'b1;
        if (i_cur_valid) state_nx = S_RUN;
      end
      S_RUN: begin
        o_run    = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (neuron_done) state_nx = last_idx ? S_STEP_END : S_REQ;
      end
      S_STEP_END: state_nx = step_last ? S_DONE : S_REQ;
      S_DONE: begin
        o_done   = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= '0;
      learn_r    <= 1'b0;
      steps_r    <= '0;
      step_cnt   <= '0;
      cnt        <= '0;
      exc_r      <= '0;
      inh_r      <= '0;
      shadow     <= '0;
      spike_vec  <= '0;
      err        <= 1'b0;
      step_valid <= 1'b0;
    end else begin
      step_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            learn_r   <= i_learn;
            steps_r   <= i_num_steps;
            err       <= 1'b0;
            step_cnt  <= '0;
            spike_vec <= '0;
            shadow    <= '0;
            idx       <= '0;
            cnt       <= '0;
          end
        end
        S_INIT:      cnt <= '0;
        S_INIT_WAIT: cnt <= cnt + CNT_W'(1);
        S_REQ: begin
          if (i_cur_valid) begin
            exc_r <= i_exc_cur;
            inh_r <= i_inh_cur;
          end
        end
        S_RUN: cnt <= '0;
        S_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          // a timed-out neuron leaves its shadow bit at the cleared value 0
          if (i_valid) begin
            shadow[idx] <= i_spike;
            if (i_neuron_idx != idx) err <= 1'b1;
          end else if (timeout_hit) begin
            err <= 1'b1;
          end
          if (neuron_done) idx <= last_idx ? 5'd0 : idx + 5'd1;
        end
        S_STEP_END: begin
          spike_vec  <= shadow;
          shadow     <= '0;
          step_valid <= 1'b1;
          step_cnt   <= step_cnt + STEP_W'(1);
          idx        <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_busy        = (state != S_IDLE) && (state != S_DONE);
  assign o_s_lern      = o_busy && learn_r;
  assign o_s_infr      = o_busy && !learn_r;
  assign o_cur_idx     = idx;
  assign o_exc_current = exc_r;
  assign o_inh_current = inh_r;
  assign o_spike_vec   = spike_vec;
  assign o_step_valid  = step_valid;
  assign o_step_cnt    = step_cnt;
  assign o_err         = err;

endmodule

// File: tb/tb_neuron_step_scheduler.sv
// tb/tb_neuron_step_scheduler.sv - directed bench with current-source and engine models
module tb_neuron_step_scheduler;

  localparam int N       = 18;
  localparam int TIMEOUT = 32;
  localparam logic [4:0] NONE = 5'd31;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start, i_init_req, i_learn;
  logic [15:0] i_num_steps;
  logic        o_cur_req;
  logic [4:0]  o_cur_idx;
  logic        i_cur_valid = 1'b1;
  logic [24:0] i_exc_cur, i_inh_cur;
  logic        o_run, o_init, o_s_lern, o_s_infr;
  logic [24:0] o_exc_current, o_inh_current;
  logic        i_spike = 1'b0;
  logic        i_valid = 1'b0;
  logic [4:0]  i_neuron_idx = 5'd0;
  logic        o_busy;
  logic [N-1:0] o_spike_vec;
  logic        o_step_valid;
  logic [15:0] o_step_cnt;
  logic        o_done, o_err;

  always #5 clk = ~clk;

  neuron_step_scheduler #(.N_NEURON(N), .STEP_W(16), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_init_req(i_init_req),
    .i_learn(i_learn), .i_num_steps(i_num_steps), .o_cur_req(o_cur_req),
    .o_cur_idx(o_cur_idx), .i_cur_valid(i_cur_valid), .i_exc_cur(i_exc_cur),
    .i_inh_cur(i_inh_cur), .o_run(o_run), .o_init(o_init), .o_s_lern(o_s_lern),
    .o_s_infr(o_s_infr), .o_exc_current(o_exc_current), .o_inh_current(o_inh_current),
    .i_spike(i_spike), .i_valid(i_valid), .i_neuron_idx(i_neuron_idx), .o_busy(o_busy),
    .o_spike_vec(o_spike_vec), .o_step_valid(o_step_valid), .o_step_cnt(o_step_cnt),
    .o_done(o_done), .o_err(o_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  logic [N-1:0] spike_mask = '0;
  logic [4:0]   drop_idx   = NONE;
  logic [4:0]   bad_idx    = NONE;
  logic [4:0]   delay_idx  = NONE;

  // current source: valid immediately, except delayed 5 cycles for delay_idx
  int req_cycles = 0;
  int req_hold   = 0;
  always @(negedge clk) begin
    if (o_cur_req && o_cur_idx == delay_idx) begin
      req_cycles  = req_cycles + 1;
      i_cur_valid = (req_cycles > 5);
      if (req_cycles > req_hold) req_hold = req_cycles;
    end else begin
      req_cycles  = 0;
      i_cur_valid = 1'b1;
    end
  end

  // engine: answers 11 cycles after run unless told to drop or misreport the index
  int         eng_cnt = 0;
  logic [4:0] eng_idx = 5'd0;
  always @(negedge clk) begin
    i_valid = 1'b0;
    if (reset) begin
      eng_cnt = 0;
    end else if (o_run) begin
      eng_cnt = 11;
      eng_idx = o_cur_idx;
    end else if (eng_cnt != 0) begin
      eng_cnt = eng_cnt - 1;
      if (eng_cnt == 0 && eng_idx != drop_idx) begin
        i_valid      = 1'b1;
        i_spike      = spike_mask[eng_idx];
        i_neuron_idx = (eng_idx == bad_idx) ? 5'(eng_idx + 5'd1) : eng_idx;
      end
    end
  end

  int cyc = 0, run_cnt = 0, init_cnt = 0, sv_cnt = 0, done_cnt = 0, busy_cnt = 0;
  int overlap_cnt = 0, lern_cnt = 0, infr_cnt = 0, run5_cyc = 0, err_rise_cyc = 0;
  logic [11:0] step_seq = '0;
  logic [24:0] exc7 = '0, inh7 = '0;
  logic        err_d = 1'b0;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (o_run) begin
      run_cnt = run_cnt + 1;
      if (o_cur_idx == 5'd7) begin exc7 = o_exc_current; inh7 = o_inh_current; end
      if (o_cur_idx == 5'd5) run5_cyc = cyc;
    end
    if (o_init) init_cnt = init_cnt + 1;
    if (o_run && o_init) overlap_cnt = overlap_cnt + 1;
    if (o_step_valid) begin
      sv_cnt   = sv_cnt + 1;
      step_seq = {step_seq[7:0], o_step_cnt[3:0]};
    end
    if (o_done) done_cnt = done_cnt + 1;
    if (o_busy) busy_cnt = busy_cnt + 1;
    if (o_s_lern) lern_cnt = lern_cnt + 1;
    if (o_s_infr) infr_cnt = infr_cnt + 1;
    if (o_err && !err_d) err_rise_cyc = cyc;
    err_d = o_err;
  end

  task automatic start_run(input logic init, input logic learn, input logic [15:0] steps);
    @(negedge clk);
    i_start = 1'b1; i_init_req = init; i_learn = learn; i_num_steps = steps;
    @(negedge clk);
    i_start = 1'b0; i_init_req = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string tag);
    for (int i = 0; i < budget && done_cnt == d0; i++) @(negedge clk);
    check_eq(tag, done_cnt - d0, 1);
    repeat (2) @(negedge clk);
  endtask

  int r0, i0, s0, d0, b0, l0, f0;
  task automatic snap();
    r0 = run_cnt; i0 = init_cnt; s0 = sv_cnt; d0 = done_cnt;
    b0 = busy_cnt; l0 = lern_cnt; f0 = infr_cnt;
  endtask

  initial begin
    reset = 1'b1; i_start = 1'b0; i_init_req = 1'b0; i_learn = 1'b0; i_num_steps = '0;
    i_exc_cur = 25'h0010000; i_inh_cur = 25'h1FF0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_flags", {o_busy, o_run, o_init, o_cur_req, o_done, o_err, o_s_lern, o_s_infr}, 0);
    check_eq("rst_vec", o_spike_vec, 0);
    check_eq("rst_cnt", o_step_cnt, 0);

    // init sweep only
    snap();
    start_run(1'b1, 1'b0, 16'd0);
    wait_done(d0, 200, "t1_done");
    check_eq("t1_init", init_cnt - i0, 1);
    check_eq("t1_busy", busy_cnt - b0, N + 2);
    check_eq("t1_runs", run_cnt - r0, 0);

    // learn, one step, spikes on 3 and 17
    spike_mask = 18'h20008;
    snap();
    start_run(1'b0, 1'b1, 16'd1);
    wait_done(d0, 3000, "t2_done");
    check_eq("t2_runs", run_cnt - r0, N);
    check_eq("t2_vec", o_spike_vec, 18'h20008);
    check_eq("t2_lern", lern_cnt - l0, busy_cnt - b0);
    check_eq("t2_infr", infr_cnt - f0, 0);
    check_eq("t2_cnt", o_step_cnt, 1);
    check_eq("t2_err", o_err, 0);

    // inference, three steps
    spike_mask = 18'h2AAAA;
    snap();
    start_run(1'b0, 1'b0, 16'd3);
    wait_done(d0, 3000, "t3_done");
    check_eq("t3_sv", sv_cnt - s0, 3);
    check_eq("t3_seq", step_seq, 12'h123);
    check_eq("t3_infr", infr_cnt - f0, busy_cnt - b0);
    check_eq("t3_lern", lern_cnt - l0, 0);
    check_eq("t3_runs", run_cnt - r0, 3 * N);
    check_eq("t3_vec", o_spike_vec, 18'h2AAAA);

    // delayed currents on neuron 7
    spike_mask = '0; delay_idx = 5'd7;
    snap();
    start_run(1'b0, 1'b0, 16'd1);
    wait_done(d0, 3000, "t4_done");
    check_eq("t4_hold", req_hold, 6);
    check_eq("t4_exc", exc7, 25'h0010000);
    check_eq("t4_inh", inh7, 25'h1FF0000);
    check_eq("t4_runs", run_cnt - r0, N);

    // dropped answer on neuron 5 times out
    delay_idx = NONE; drop_idx = 5'd5; spike_mask = 18'h3FFFF;
    snap();
    start_run(1'b0, 1'b1, 16'd1);
    wait_done(d0, 3000, "t5_done");
    check_eq("t5_err", o_err, 1);
    check_eq("t5_vec", o_spike_vec, 18'h3FFDF);
    // error becomes visible the cycle after the TIMEOUT-th WAIT cycle
    check_eq("t5_tmo", err_rise_cyc - run5_cyc, TIMEOUT + 1);
    check_eq("t5_runs", run_cnt - r0, N);

    // wrong index returned for neuron 8
    drop_idx = NONE; bad_idx = 5'd8;
    snap();
    start_run(1'b0, 1'b1, 16'd1);
    check_eq("t5b_clr", o_err, 0);
    wait_done(d0, 3000, "t5b_done");
    check_eq("t5b_err", o_err, 1);
    check_eq("t5b_vec", o_spike_vec, 18'h3FFFF);

    // reset during step 2
    bad_idx = NONE; spike_mask = 18'h00F0F;
    snap();
    start_run(1'b0, 1'b1, 16'd3);
    for (int i = 0; i < 1000 && sv_cnt == s0; i++) @(negedge clk);
    check_eq("t6_step1", o_step_cnt, 1);
    repeat (60) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("t6_flags", {o_busy, o_run, o_init, o_cur_req, o_done, o_err, o_s_lern, o_s_infr, o_step_valid}, 0);
    check_eq("t6_vec", o_spike_vec, 0);
    check_eq("t6_cnt", o_step_cnt, 0);
    check_eq("t6_cur", {o_exc_current, o_cur_idx}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("t6_nodone", done_cnt - d0, 0);

    // start pulse while busy is ignored
    snap();
    start_run(1'b0, 1'b0, 16'd2);
    repeat (30) @(negedge clk);
    start_run(1'b1, 1'b1, 16'd1);
    wait_done(d0, 3000, "t6b_done");
    check_eq("t6b_cnt", o_step_cnt, 2);
    check_eq("t6b_sv", sv_cnt - s0, 2);
    check_eq("t6b_init", init_cnt - i0, 0);
    check_eq("t6b_lern", lern_cnt - l0, 0);
    check_eq("overlap", overlap_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
